// File: rtl/passcode_controller_pkg.sv
// Shared definitions for the passcode controller and the door-lock state manager.
// Holds the 3-bit state-manager encodings, keypad code constants and the digit type.
package passcode_controller_pkg;

    // State manager encodings (shared with the state manager)
    localparam logic [2:0] ST_OFF    = 3'b000;
    localparam logic [2:0] ST_ON     = 3'b001;
    localparam logic [2:0] ST_WRONG1 = 3'b010;
    localparam logic [2:0] ST_WRONG2 = 3'b011;
    localparam logic [2:0] ST_ANSWER = 3'b100;
    localparam logic [2:0] ST_RESET  = 3'b101;
    localparam logic [2:0] ST_LOCK   = 3'b111;

    typedef logic [3:0] digit_t;

    localparam digit_t KEY_MAX_DIGIT = 4'h9;
    localparam digit_t KEY_BKSP      = 4'hA;

    // States in which keypad input is collected
    function automatic logic key_state(input logic [2:0] st);
        return (st == ST_ON) || (st == ST_WRONG1) || (st == ST_WRONG2) || (st == ST_RESET);
    endfunction

endpackage

// File: rtl/passcode_controller_lockout_timer.sv
// Lockout period timer.
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        count while high; low clears the counter
//   expired_pulse one-cycle pulse at the last cycle of each LOCK_CYCLES period
module lockout_timer
#(
    parameter int unsigned LOCK_CYCLES = 50000000
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic expired_pulse
);

    localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d         = '0;
        expired_pulse = 1'b0;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                expired_pulse = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/passcode_controller.sv
// Digit-entry and passcode-compare controller for the door lock.
// Collects keypad digits, compares them against the stored code, commits a new code
// when leaving the reset state, and times lockout periods.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   state        state manager state (3 bits)
//   key_valid    single-cycle key strobe
//   key_code     0-9 digit, 4'hA backspace, others ignored
//   correct      code match (on/wrong1/wrong2) or new code long enough (reset)
//   entry_len    number of digits buffered
//   entry_full   buffer holds MAX_DIGITS digits
//   lock_expired one-cycle pulse per completed lockout period
module passcode_controller
    import passcode_controller_pkg::*;
#(
    parameter int unsigned MAX_DIGITS  = 8,
    parameter int unsigned MIN_DIGITS  = 4,
    parameter int unsigned DEFAULT_LEN = 4,
    parameter int unsigned LOCK_CYCLES = 50000000,
    localparam int unsigned LEN_W      = $clog2(MAX_DIGITS + 1)
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       state,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             correct,
    output logic [LEN_W-1:0] entry_len,
    output logic             entry_full,
    output logic             lock_expired
);

    logic [2:0]                 state_q;
    digit_t [MAX_DIGITS-1:0]    entry_q, entry_d;
    digit_t [MAX_DIGITS-1:0]    code_q, code_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           code_len_q, code_len_d;
    logic                       code_match;
    logic                       lock_active;

    // Entry buffer and commit. A state change has priority over any key in the same cycle.
    always_comb begin
        entry_d    = entry_q;
        len_d      = len_q;
        code_d     = code_q;
        code_len_d = code_len_q;
        if (state != state_q) begin
            len_d = '0;
            // Leaving reset for on with a long enough entry commits the pre-clear buffer
            if ((state_q == ST_RESET) && (state == ST_ON) &&
                (len_q >= LEN_W'(MIN_DIGITS))) begin
                code_d     = entry_q;
                code_len_d = len_q;
            end
        end else if (key_valid && key_state(state)) begin
            if (key_code <= KEY_MAX_DIGIT) begin
                if (len_q < LEN_W'(MAX_DIGITS)) begin
                    for (int i = 0; i < MAX_DIGITS; i++) begin
                        if (LEN_W'(i) == len_q) begin
                            entry_d[i] = key_code;
                        end
                    end
                    len_d = len_q + 1'b1;
                end
            end else if ((key_code == KEY_BKSP) && (len_q != '0)) begin
                len_d = len_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            entry_q    <= '0;
            len_q      <= '0;
            code_q     <= '0;
            code_len_q <= LEN_W'(DEFAULT_LEN);
        end else begin
            state_q    <= state;
            entry_q    <= entry_d;
            len_q      <= len_d;
            code_q     <= code_d;
            code_len_q <= code_len_d;
        end
    end

    // Only the first code_len_q digits take part; slots beyond are stale
    always_comb begin
        code_match = (len_q == code_len_q);
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((LEN_W'(i) < code_len_q) && (entry_q[i] != code_q[i])) begin
                code_match = 1'b0;
            end
        end
    end

    always_comb begin
        correct = 1'b0;
        case (state)
            ST_ON, ST_WRONG1, ST_WRONG2: correct = code_match;
            ST_RESET:                    correct = (len_q >= LEN_W'(MIN_DIGITS));
            default:                     correct = 1'b0;
        endcase
    end

    assign entry_len   = len_q;
    assign entry_full  = (len_q == LEN_W'(MAX_DIGITS));
    assign lock_active = (state == ST_LOCK);

    lockout_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lockout_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (lock_active),
        .expired_pulse (lock_expired)
    );

endmodule

// File: tb/tb_passcode_controller.sv
// Scoreboard bench for passcode_controller: directed sequences then random stimulus.
module tb_passcode_controller;

    localparam int MAXD  = 8;
    localparam int MIND  = 4;
    localparam int DEFL  = 4;
    localparam int LOCKC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state = 3'd0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       correct;
    logic [3:0] entry_len;
    logic       entry_full;
    logic       lock_expired;

    passcode_controller #(
        .MAX_DIGITS  (MAXD),
        .MIN_DIGITS  (MIND),
        .DEFAULT_LEN (DEFL),
        .LOCK_CYCLES (LOCKC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .correct      (correct),
        .entry_len    (entry_len),
        .entry_full   (entry_full),
        .lock_expired (lock_expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int full;
        int corr;
        int lock;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    // Reference model: digits as queues, lockout as a run length of locked cycles
    int m_entry[$];
    int m_code[$];
    int m_prev;
    int m_lock_run;

    function automatic void model_reset();
        m_entry.delete();
        m_code.delete();
        for (int i = 0; i < DEFL; i++) m_code.push_back(0);
        m_prev     = 0;
        m_lock_run = 0;
    endfunction

    function automatic int model_match();
        if (m_entry.size() != m_code.size()) return 0;
        for (int i = 0; i < m_entry.size(); i++) begin
            if (m_entry[i] != m_code[i]) return 0;
        end
        return 1;
    endfunction

    function automatic void model_advance(input int st, input bit kv, input int kc);
        if (st != m_prev) begin
            if (m_prev == 5 && st == 1 && m_entry.size() >= MIND) m_code = m_entry;
            m_entry.delete();
        end else if (kv && (st == 1 || st == 2 || st == 3 || st == 5)) begin
            if (kc <= 9) begin
                if (m_entry.size() < MAXD) m_entry.push_back(kc);
            end else if (kc == 10 && m_entry.size() > 0) begin
                void'(m_entry.pop_back());
            end
        end
        m_prev     = st;
        m_lock_run = (st == 7) ? m_lock_run + 1 : 0;
    endfunction

    // One clock cycle of stimulus; expected outputs for this cycle go to the scoreboard
    task automatic step(input bit rst, input int st, input bit kv, input int kc);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        state     = st[2:0];
        key_valid = kv;
        key_code  = kc[3:0];
        if (!rst) model_reset();
        e.len  = m_entry.size();
        e.full = (m_entry.size() == MAXD) ? 1 : 0;
        if (st == 1 || st == 2 || st == 3) e.corr = model_match();
        else if (st == 5)                  e.corr = (m_entry.size() >= MIND) ? 1 : 0;
        else                               e.corr = 0;
        e.lock = (rst && st == 7 && ((m_lock_run + 1) % LOCKC == 0)) ? 1 : 0;
        e.cyc  = cyc;
        sb.push_back(e);
        @(posedge clk);
        if (rst) model_advance(st, kv, kc);
        cyc++;
    endtask

    task automatic keys(input int st, input int k0, input int k1, input int k2, input int k3);
        int ks[4];
        ks = '{k0, k1, k2, k3};
        foreach (ks[i]) if (ks[i] >= 0) step(1'b1, st, 1'b1, ks[i]);
    endtask

    task automatic idle(input int st, input int n);
        for (int i = 0; i < n; i++) step(1'b1, st, 1'b0, 0);
    endtask

    function automatic void check(input string name, input int got, input int want, input int c);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL cycle %0d %s: got %0d expected %0d", c, name, got, want);
        end
    endfunction

    // Monitor: outputs are presented every cycle; compare mid-cycle after inputs settle
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("entry_len", int'(entry_len), e.len, e.cyc);
            check("entry_full", int'(entry_full), e.full, e.cyc);
            check("correct", int'(correct), e.corr, e.cyc);
            check("lock_expired", int'(lock_expired), e.lock, e.cyc);
        end
    end

    initial begin
        int st;
        int kc;
        bit kv;
        int states[7];
        states = '{0, 1, 2, 3, 4, 5, 7};
        model_reset();
        step(1'b0, 0, 1'b0, 0);
        step(1'b0, 1, 1'b1, 3);

        // Default code 0000, then a fifth digit breaks the match
        idle(1, 1);
        keys(1, 0, 0, 0, 0);
        keys(1, 0, -1, -1, -1);
        idle(1, 1);

        // Backspaces down to empty and then the default code
        idle(4, 1);
        idle(1, 1);
        keys(1, 1, 2, 3, 10);
        keys(1, 10, 10, 0, 0);
        keys(1, 0, 0, -1, -1);
        idle(1, 1);

        // New code 5678 qualified in reset state and committed on 101 -> 001
        idle(4, 1);
        idle(5, 1);
        keys(5, 5, 6, 7, -1);
        idle(5, 1);
        keys(5, 8, -1, -1, -1);
        idle(5, 1);
        idle(1, 1);
        keys(1, 5, 6, 7, 8);
        idle(1, 1);
        idle(2, 1);
        keys(2, 0, 0, 0, 0);
        idle(2, 1);

        // Short code in reset state is not committed
        step(1'b0, 0, 1'b0, 0);
        idle(5, 1);
        keys(5, 9, 9, -1, -1);
        idle(1, 1);
        keys(1, 0, 0, 0, 0);
        idle(1, 1);

        // Buffer overflow, then a key coincident with a state change
        idle(1, 1);
        keys(1, 1, 2, 3, 4);
        keys(1, 5, 6, 7, 8);
        keys(1, 9, -1, -1, -1);
        idle(1, 1);
        step(1'b1, 2, 1'b1, 4);
        idle(2, 1);

        // Lockout: continuous, interrupted, and reset mid-lock
        idle(7, 20);
        idle(0, 2);
        idle(7, 12);
        idle(0, 2);
        idle(7, 5);
        step(1'b0, 7, 1'b0, 0);
        step(1'b0, 7, 1'b0, 0);
        idle(7, 9);
        idle(1, 1);
        keys(1, 0, 0, 0, 0);
        idle(1, 1);

        // Random phase
        st = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) st = states[$urandom_range(0, 6)];
            kv = ($urandom_range(0, 2) != 0);
            kc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) step(1'b0, st, kv, kc);
            else                             step(1'b1, st, kv, kc);
        end

        repeat (3) @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
